frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
Sequencer between the preemphasis stage and the FFT/window stage of the log-mel front end. Accepts the preemphasized sample stream (17-bit, valid-only, no backpressure) into a ring buffer. Replays it as overlapping frames of FRAME_LEN samples advanced by HOP, over a valid/ready handshake with sof/eof markers. Drops samples and flags overflow when downstream stalls long enough to fill the buffer.

Parameters:
D_BW, 17, sample width (matches preemphasis O_BW)
FRAME_LEN, 400, samples per frame
HOP, 160, frame advance in samples; 1 <= HOP <= FRAME_LEN
AW, 9, ring address width; DEPTH = 2**AW >= FRAME_LEN
FC_BW, 16, frame counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  input sample strobe from preemphasis
data_i  in  D_BW  input sample, signed
ready_i  in  1  downstream accepts output word
valid_o  out  1  output word valid
data_o  out  D_BW  frame sample
sof_o  out  1  first sample of frame, qualified by valid_o
eof_o  out  1  last sample of frame, qualified by valid_o
frame_cnt_o  out  FC_BW  index of frame currently or next emitted
overflow_o  out  1  sticky: at least one input sample dropped

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, frame_start=0, rd_idx=0, state IDLE; valid_o=0, data_o=0, sof_o=0, eof_o=0, frame_cnt_o=0, overflow_o=0. Buffer contents undefined and irrelevant. Reset mid-frame aborts the frame with no eof.
- fill = wr_ptr - frame_start, computed in AW+1 bits: the count of stored samples not yet released.
- Write: on a clk edge with valid_i=1 and fill<DEPTH, store data_i at wr_ptr and increment wr_ptr (wraps mod DEPTH). With fill==DEPTH, drop the sample and set overflow_o=1 until reset. A write is always legal in the same cycle as a read.
- FSM states:
  - IDLE: when fill>=FRAME_LEN, load output reg with buf[frame_start], set valid_o=1, sof_o=1, eof_o=(FRAME_LEN==1), rd_idx=1, go to STREAM. The fill check uses the registered fill, so valid_o rises on the 2nd rising edge after the edge writing the FRAME_LEN-th sample.
  - STREAM: on handshake (valid_o & ready_i):
    - if eof_o: valid_o=0; frame_start += HOP (releases HOP slots); frame_cnt_o += 1 (wraps); go to IDLE.
    - else: load buf[frame_start+rd_idx], sof_o=0, eof_o=(rd_idx==FRAME_LEN-1), rd_idx += 1.
  - Without handshake, data_o/sof_o/eof_o/valid_o hold stable.
- Throughput: one word per cycle while ready_i=1. Exactly one idle cycle (valid_o=0) between frames, even when the next frame's data is already buffered.
- Frame f, word k (0-based) = the (f*HOP+k)-th accepted input sample since reset. Dropped samples are not counted.
- Samples at index >= frame_start are never overwritten, so overlap regions stay intact.
- All pointers wrap mod DEPTH; fill arithmetic is correct across wrap.

Decomposition:
- Package mel_pkg: D_BW, FRAME_LEN, HOP, AW constants; typedef sample_t (signed [D_BW-1:0]); state enum {IDLE, STREAM}.
- Sub-module frame_ring_buffer: DEPTH x D_BW storage, one synchronous write port, one combinational read port (address -> data). Top holds the FSM, pointers and output register.

Test Plan (FRAME_LEN=8, HOP=4, AW=4 unless noted; inputs are ramp 0,1,2,... one per cycle):
- Basic framing, ready_i=1 -> frame0 = 0..7 with sof on 0 and eof on 7; frame1 = 4..11; frame2 = 8..15; frame_cnt_o 0,1,2; valid_o rises 2 edges after sample 7 is written.
- Backpressure: toggle ready_i 1/0 every cycle -> same word sequences; data_o/sof_o/eof_o stable on every ready_i=0 cycle; no overflow_o.
- Overflow: ready_i=0 for 40 cycles with continuous input -> fill saturates at 16, overflow_o=1 from the edge of the 17th sample. Then ready_i=1 -> frame0 = 0..7, frame1 = 4..11, frame2 = 8..15; samples 16..39 absent.
- Wrap: 100 frames with ready_i=1 -> frame f starts with value 4f; frame_cnt_o reaches 100; no corruption across pointer wrap.
- Reset mid-frame: assert rst_n=0 at word 3 of frame 2 -> all outputs 0 immediately (async). After release with a new ramp, frame0 = 0..7 and frame_cnt_o=0.
- Edge parameters: HOP=FRAME_LEN=8 -> non-overlapping 0..7, 8..15. FRAME_LEN=1, HOP=1 -> every word has sof_o=eof_o=1.

Source files
------------

// File: rtl/mel_pkg.sv
// Shared constants and types for the log-mel front end.
// Defaults describe a 400-sample frame with a 160-sample hop.
package mel_pkg;
    localparam int D_BW      = 17;
    localparam int FRAME_LEN = 400;
    localparam int HOP       = 160;
    localparam int AW        = 9;
    localparam int FC_BW     = 16;

    typedef logic signed [D_BW-1:0] sample_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;
endpackage

// File: rtl/frame_ring_buffer.sv
// Sample storage for the frame scheduler.
// One synchronous write port and one combinational read port.
module frame_ring_buffer #(
    parameter int D_BW = 17,
    parameter int AW   = 9
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic signed [D_BW-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic signed [D_BW-1:0] rd_data
);
    localparam int DEPTH = 2 ** AW;

    logic signed [D_BW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/frame_scheduler.sv
// Buffers the preemphasized stream and replays it as overlapping frames
// of FRAME_LEN samples advanced by HOP, over a valid/ready handshake.
module frame_scheduler #(
    parameter int D_BW      = mel_pkg::D_BW,
    parameter int FRAME_LEN = mel_pkg::FRAME_LEN,
    parameter int HOP       = mel_pkg::HOP,
    parameter int AW        = mel_pkg::AW,
    parameter int FC_BW     = mel_pkg::FC_BW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic signed [D_BW-1:0] data_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic signed [D_BW-1:0] data_o,
    output logic                   sof_o,
    output logic                   eof_o,
    output logic [FC_BW-1:0]       frame_cnt_o,
    output logic                   overflow_o
);
    import mel_pkg::*;

    localparam int DEPTH = 2 ** AW;

    state_t                 state_reg;
    logic [AW:0]            wr_ptr_reg;
    logic [AW:0]            frame_start_reg;
    logic [AW:0]            frame_start_next;
    logic [AW:0]            fill_reg;
    logic [AW:0]            fill;
    logic [AW-1:0]          rd_idx_reg;
    logic [AW-1:0]          rd_addr;
    logic signed [D_BW-1:0] rd_data;
    logic                   wr_en;
    logic                   frame_done;

    // Pointers carry one extra bit so a completely full ring reads as DEPTH, not 0.
    assign fill       = wr_ptr_reg - frame_start_reg;
    assign wr_en      = valid_i && (fill != (AW+1)'(DEPTH));
    assign frame_done = (state_reg == STREAM) && valid_o && ready_i && eof_o;
    assign frame_start_next = frame_done ? frame_start_reg + (AW+1)'(HOP) : frame_start_reg;
    assign rd_addr    = frame_start_reg[AW-1:0] + rd_idx_reg;

    frame_ring_buffer #(
        .D_BW (D_BW),
        .AW   (AW)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            frame_start_reg <= '0;
            fill_reg        <= '0;
            rd_idx_reg      <= '0;
            valid_o         <= 1'b0;
            data_o          <= '0;
            sof_o           <= 1'b0;
            eof_o           <= 1'b0;
            frame_cnt_o     <= '0;
            overflow_o      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end else if (valid_i) begin
                overflow_o <= 1'b1;
            end
            frame_start_reg <= frame_start_next;
            // Old write pointer against the new frame start: never overstates what is stored.
            fill_reg <= wr_ptr_reg - frame_start_next;

            case (state_reg)
                IDLE: begin
                    if (fill_reg >= (AW+1)'(FRAME_LEN)) begin
                        valid_o    <= 1'b1;
                        data_o     <= rd_data;
                        sof_o      <= 1'b1;
                        eof_o      <= (FRAME_LEN == 1);
                        rd_idx_reg <= AW'(1);
                        state_reg  <= STREAM;
                    end
                end
                STREAM: begin
                    if (valid_o && ready_i) begin
                        if (eof_o) begin
                            valid_o     <= 1'b0;
                            sof_o       <= 1'b0;
                            eof_o       <= 1'b0;
                            rd_idx_reg  <= '0;
                            frame_cnt_o <= frame_cnt_o + FC_BW'(1);
                            state_reg   <= IDLE;
                        end else begin
                            data_o     <= rd_data;
                            sof_o      <= 1'b0;
                            eof_o      <= (rd_idx_reg == AW'(FRAME_LEN - 1));
                            rd_idx_reg <= rd_idx_reg + AW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: three parameter sets driven by shared stimulus,
// each checked every cycle against a sample-index model of the framing rules.
module tb_frame_scheduler;
    localparam int DW    = 17;
    localparam int NI    = 3;
    localparam int DEPTH = 16;
    localparam int MAXS  = 4096;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } hs_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_i = 1'b0;
    logic signed [DW-1:0] data_i = '0;
    logic                 ready_i = 1'b0;

    logic                 v_o   [NI];
    logic signed [DW-1:0] d_o   [NI];
    logic                 sof_o [NI];
    logic                 eof_o [NI];
    logic [15:0]          fc_o  [NI];
    logic                 ovf_o [NI];

    int errors = 0;
    int checks = 0;

    // Model state, expressed in accepted-sample indices.
    int  cyc = 0;
    int  acc [NI];
    int  done [NI];
    int  wk [NI];
    bit  m_valid [NI];
    bit  m_sof [NI];
    bit  m_eof [NI];
    bit  m_ovf [NI];
    int  m_data [NI];
    int  samp [NI][MAXS];
    int  aedge [NI][MAXS];
    hs_t hs_q [NI][$];

    always #5 clk = ~clk;

    frame_scheduler #(.D_BW(DW), .FRAME_LEN(8), .HOP(4), .AW(4), .FC_BW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(v_o[0]), .data_o(d_o[0]), .sof_o(sof_o[0]), .eof_o(eof_o[0]),
        .frame_cnt_o(fc_o[0]), .overflow_o(ovf_o[0]));

    frame_scheduler #(.D_BW(DW), .FRAME_LEN(8), .HOP(8), .AW(4), .FC_BW(16)) u_dut_nov (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(v_o[1]), .data_o(d_o[1]), .sof_o(sof_o[1]), .eof_o(eof_o[1]),
        .frame_cnt_o(fc_o[1]), .overflow_o(ovf_o[1]));

    frame_scheduler #(.D_BW(DW), .FRAME_LEN(1), .HOP(1), .AW(4), .FC_BW(16)) u_dut_one (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(v_o[2]), .data_o(d_o[2]), .sof_o(sof_o[2]), .eof_o(eof_o[2]),
        .frame_cnt_o(fc_o[2]), .overflow_o(ovf_o[2]));

    function automatic int fl_of(int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int hop_of(int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame f word k is accepted sample f*HOP+k; a frame may start once its
    // last sample has been stored for two edges; DEPTH unreleased samples block writes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                acc[i] = 0; done[i] = 0; wk[i] = 0;
                m_valid[i] = 0; m_sof[i] = 0; m_eof[i] = 0; m_ovf[i] = 0; m_data[i] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) begin
                int done_old;
                int last;
                done_old = done[i];
                if (!m_valid[i]) begin
                    last = done[i] * hop_of(i) + fl_of(i) - 1;
                    if (acc[i] > last && aedge[i][last] <= cyc - 2) begin
                        m_valid[i] = 1;
                        wk[i] = 0;
                        m_data[i] = samp[i][done[i] * hop_of(i)];
                        m_sof[i] = 1;
                        m_eof[i] = (fl_of(i) == 1);
                    end
                end else if (ready_i) begin
                    if (m_eof[i]) begin
                        m_valid[i] = 0;
                        done[i] = done[i] + 1;
                    end else begin
                        wk[i] = wk[i] + 1;
                        m_data[i] = samp[i][done[i] * hop_of(i) + wk[i]];
                        m_sof[i] = 0;
                        m_eof[i] = (wk[i] == fl_of(i) - 1);
                    end
                end
                if (valid_i) begin
                    if (acc[i] - done_old * hop_of(i) == DEPTH) begin
                        m_ovf[i] = 1;
                    end else if (acc[i] < MAXS) begin
                        samp[i][acc[i]] = int'(data_i);
                        aedge[i][acc[i]] = cyc;
                        acc[i] = acc[i] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) hs_q[i].delete();
        end else begin
            for (int i = 0; i < NI; i++)
                if (v_o[i] && ready_i) hs_q[i].push_back({d_o[i], sof_o[i], eof_o[i]});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d valid_o", i), int'(v_o[i]), int'(m_valid[i]));
                if (m_valid[i]) begin
                    chk($sformatf("u%0d data_o", i), int'(d_o[i]), m_data[i]);
                    chk($sformatf("u%0d sof_o", i), int'(sof_o[i]), int'(m_sof[i]));
                    chk($sformatf("u%0d eof_o", i), int'(eof_o[i]), int'(m_eof[i]));
                end
                chk($sformatf("u%0d frame_cnt_o", i), int'(fc_o[i]), done[i] % 65536);
                chk($sformatf("u%0d overflow_o", i), int'(ovf_o[i]), int'(m_ovf[i]));
            end
        end
    end

    task automatic step(input logic v, input int d, input logic r);
        @(negedge clk);
        valid_i = v;
        data_i  = DW'(d);
        ready_i = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_word(string nm, int inst, int j, int d, bit s, bit e);
        if (j >= hs_q[inst].size())
            chk({nm, " missing"}, hs_q[inst].size(), j + 1);
        else
            chk(nm, int'(hs_q[inst][j].d) * 4 + int'(hs_q[inst][j].s) * 2 + int'(hs_q[inst][j].e),
                d * 4 + int'(s) * 2 + int'(e));
    endtask

    initial begin
        int n;
        int sent;
        do_reset();

        // Basic framing with ready held high.
        for (int s = 0; s < 8; s++) step(1, s, 1);
        step(1, 8, 1);  chk("rise edge+1 valid", int'(v_o[0]), 0);
        step(1, 9, 1);  chk("rise edge+2 valid", int'(v_o[0]), 0);
        step(1, 10, 1); chk("rise edge+3 valid", int'(v_o[0]), 1);
        chk("first word", int'(d_o[0]) * 2 + int'(sof_o[0]), 1);
        for (int s = 11; s < 16; s++) step(1, s, 1);
        n = 0;
        do begin
            step(0, 0, 1);
            n++;
        end while (!(v_o[0] && fc_o[0] == 16'd2 && d_o[0] == 17'sd11) && n < 100);
        chk("reach frame2 word3", int'(n < 100), 1);
        chk_word("f0 w0", 0, 0, 0, 1, 0);
        chk_word("f0 w7", 0, 7, 7, 0, 1);
        chk_word("f1 w0", 0, 8, 4, 1, 0);
        chk_word("f1 w7", 0, 15, 11, 0, 1);
        chk_word("f2 w0", 0, 16, 8, 1, 0);
        chk_word("nov f1 w0", 1, 8, 8, 1, 0);
        chk_word("nov f1 w7", 1, 15, 15, 0, 1);
        chk_word("one f5", 2, 5, 5, 1, 1);

        // Asynchronous reset in the middle of frame 2.
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst u%0d outputs", i),
                int'(v_o[i]) + int'(sof_o[i]) + int'(eof_o[i]) + int'(ovf_o[i]), 0);
            chk($sformatf("rst u%0d data", i), int'(d_o[i]), 0);
            chk($sformatf("rst u%0d cnt", i), int'(fc_o[i]), 0);
        end
        valid_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 10; s++) step(1, s, 1);
        step(1, 10, 1);
        chk("post-rst first word", int'(d_o[0]) * 4 + int'(sof_o[0]) * 2 + int'(v_o[0]), 3);
        chk("post-rst frame_cnt", int'(fc_o[0]), 0);
        step(1, 11, 1);
        repeat (30) step(0, 0, 1);
        chk_word("post-rst f0 w7", 0, 7, 7, 0, 1);
        chk("post-rst frames", int'(fc_o[0]), 2);

        // Backpressure: ready toggles every cycle, input kept below capacity.
        do_reset();
        for (int c = 0; c < 120; c++) step(c < 16, c, c % 2 == 0);
        chk("bp words", hs_q[0].size(), 24);
        chk_word("bp f2 w4", 0, 20, 12, 0, 0);
        chk("bp no overflow", int'(ovf_o[0]), 0);

        // Overflow: downstream stalled while input keeps arriving.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            step(1, s, 0);
            if (s == 16) chk("ovf before drop", int'(ovf_o[0]), 0);
            if (s == 17) chk("ovf after drop", int'(ovf_o[0]), 1);
        end
        repeat (60) step(0, 0, 1);
        chk("ovf words", hs_q[0].size(), 24);
        chk_word("ovf f2 w0", 0, 16, 8, 1, 0);
        chk_word("ovf f2 w7", 0, 23, 15, 0, 1);
        chk("ovf frames", int'(fc_o[0]), 3);
        chk("ovf sticky", int'(ovf_o[0]), 1);

        // Wrap: 100 frames through a 16-entry ring, input slower than output.
        do_reset();
        sent = 0;
        for (int c = 0; c < 1100; c++) begin
            if (c % 10 < 4 && sent < 404) begin
                step(1, sent, 1);
                sent++;
            end else begin
                step(0, 0, 1);
            end
        end
        n = 0;
        while (fc_o[0] != 16'd100 && n < 200) begin
            step(0, 0, 1);
            n++;
        end
        chk("wrap frame_cnt", int'(fc_o[0]), 100);
        chk_word("wrap f99 w0", 0, 792, 396, 1, 0);
        chk_word("wrap f99 w7", 0, 799, 403, 0, 1);
        chk("wrap no overflow", int'(ovf_o[0]), 0);

        // Randomized traffic: heavy then light input, random backpressure.
        do_reset();
        for (int c = 0; c < 800; c++)
            step($urandom_range(0, 99) < 60, int'($urandom), $urandom_range(0, 99) < 70);
        do_reset();
        for (int c = 0; c < 800; c++)
            step($urandom_range(0, 99) < 25, int'($urandom), $urandom_range(0, 99) < 80);
        repeat (40) step(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
